// File: rtl/bus_datapath_seq_if.sv
// Handshake, operand and observation signals of the sequenced single-bus datapath.
// The master side requests operations; the slave side is the datapath itself.
interface bus_datapath_seq_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 4
);
    logic              start;
    logic [2:0]        op;
    logic [REG_AW-1:0] ra;
    logic [REG_AW-1:0] rb;
    logic [REG_AW-1:0] rc;
    logic [DATA_W-1:0] mdatain;
    logic              ld_en;
    logic [REG_AW-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] bus_out;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output start, op, ra, rb, rc, mdatain, ld_en, ld_addr, ld_data, dbg_addr,
        input  dbg_data, busy, done, bus_out, hi_out, lo_out
    );

    modport slave (
        input  start, op, ra, rb, rc, mdatain, ld_en, ld_addr, ld_data, dbg_addr,
        output dbg_data, busy, done, bus_out, hi_out, lo_out
    );
endinterface

// File: rtl/bus_datapath_seq.sv
// Single-bus datapath (register file, Y, Z, HI, LO, MDR) with a built-in microsequencer
// that runs a whole ALU or load transfer from one start/done handshake.
module bus_datapath_seq #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_AW   = 4
) (
    input logic               clock,
    input logic               clear,
    bus_datapath_seq_if.slave bus_if
);
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpMul  = 3'd4;
    localparam logic [2:0] OpNot  = 3'd5;
    localparam logic [2:0] OpLoad = 3'd6;

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     y_q, hi_q, lo_q, mdr_q;
    logic [2*DATA_W-1:0]   z_q;
    logic [2:0]            op_q;
    logic [REG_AW-1:0]     ra_q, rb_q, rc_q;

    logic [DATA_W-1:0]     bus;
    logic                  is_alu, is_mul, is_load;
    logic                  latch, y_en, z_en, mdr_en, hi_en, lo_en, rf_we;
    logic [REG_AW-1:0]     rf_waddr;
    logic [DATA_W-1:0]     rf_wdata;
    logic [2*DATA_W-1:0]   alu_res;
    logic signed [2*DATA_W-1:0] prod;

    assign is_alu  = (op_q <= OpNot);
    assign is_mul  = (op_q == OpMul);
    assign is_load = (op_q == OpLoad);

    // Sequencer: drives the bus and the per-register load strobes for each T-state.
    always_comb begin
        state_d  = state_q;
        bus      = '0;
        latch    = 1'b0;
        y_en     = 1'b0;
        z_en     = 1'b0;
        mdr_en   = 1'b0;
        hi_en    = 1'b0;
        lo_en    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = rc_q;
        rf_wdata = '0;
        unique case (state_q)
            StIdle: begin
                if (bus_if.start) begin
                    latch   = 1'b1;
                    state_d = StT0;
                end else if (bus_if.ld_en) begin
                    rf_we    = 1'b1;
                    rf_waddr = bus_if.ld_addr;
                    rf_wdata = bus_if.ld_data;
                end
            end
            StT0: begin
                if (is_alu) begin
                    bus     = regs_q[ra_q];
                    y_en    = 1'b1;
                    state_d = StT1;
                end else if (is_load) begin
                    mdr_en  = 1'b1;
                    state_d = StT1;
                end else begin
                    state_d = StDone;
                end
            end
            StT1: begin
                if (is_alu) begin
                    bus     = regs_q[rb_q];
                    z_en    = 1'b1;
                    state_d = StT2;
                end else begin
                    bus      = mdr_q;
                    rf_we    = 1'b1;
                    rf_wdata = mdr_q;
                    state_d  = StDone;
                end
            end
            StT2: begin
                bus      = z_q[DATA_W-1:0];
                rf_we    = 1'b1;
                rf_wdata = z_q[DATA_W-1:0];
                lo_en    = is_mul;
                state_d  = is_mul ? StT3 : StDone;
            end
            StT3: begin
                bus     = z_q[2*DATA_W-1:DATA_W];
                hi_en   = 1'b1;
                state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ALU: Y is the A operand, the bus carries B during T1.
    always_comb begin
        prod    = $signed({{DATA_W{y_q[DATA_W-1]}}, y_q}) *
                  $signed({{DATA_W{bus[DATA_W-1]}}, bus});
        alu_res = '0;
        case (op_q)
            OpAdd:   alu_res = {{DATA_W{1'b0}}, y_q + bus};
            OpSub:   alu_res = {{DATA_W{1'b0}}, y_q - bus};
            OpAnd:   alu_res = {{DATA_W{1'b0}}, y_q & bus};
            OpOr:    alu_res = {{DATA_W{1'b0}}, y_q | bus};
            OpMul:   alu_res = prod;
            OpNot:   alu_res = {{DATA_W{1'b0}}, ~y_q};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            if (latch) begin
                op_q <= bus_if.op;
                ra_q <= bus_if.ra;
                rb_q <= bus_if.rb;
                rc_q <= bus_if.rc;
            end
            if (y_en)   y_q   <= bus;
            if (z_en)   z_q   <= alu_res;
            if (mdr_en) mdr_q <= bus_if.mdatain;
            if (hi_en)  hi_q  <= bus;
            if (lo_en)  lo_q  <= bus;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    assign bus_if.dbg_data = regs_q[bus_if.dbg_addr];
    assign bus_if.busy     = (state_q != StIdle);
    assign bus_if.done     = (state_q == StDone);
    assign bus_if.bus_out  = bus;
    assign bus_if.hi_out   = hi_q;
    assign bus_if.lo_out   = lo_q;
endmodule

// File: tb/tb_bus_datapath_seq.sv
// Directed bench for bus_datapath_seq at 32-bit/16-reg and 8-bit/4-reg sizes; expected
// results come from a behavioural register model and are queued at issue time.
module tb_bus_datapath_seq;
    localparam logic [2:0] OpAdd  = 3'd0;
    localparam logic [2:0] OpSub  = 3'd1;
    localparam logic [2:0] OpAnd  = 3'd2;
    localparam logic [2:0] OpOr   = 3'd3;
    localparam logic [2:0] OpMul  = 3'd4;
    localparam logic [2:0] OpNot  = 3'd5;
    localparam logic [2:0] OpLoad = 3'd6;
    localparam logic [2:0] OpNop  = 3'd7;

    logic clock = 1'b0;
    logic clear = 1'b0;

    bus_datapath_seq_if #(.DATA_W(32), .REG_AW(4)) bi32 ();
    bus_datapath_seq_if #(.DATA_W(8),  .REG_AW(2)) bi8 ();

    bus_datapath_seq #(.DATA_W(32), .NUM_REGS(16), .REG_AW(4)) dut32 (
        .clock  (clock),
        .clear  (clear),
        .bus_if (bi32)
    );

    bus_datapath_seq #(.DATA_W(8), .NUM_REGS(4), .REG_AW(2)) dut8 (
        .clock  (clock),
        .clear  (clear),
        .bus_if (bi8)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  rc;
        logic [31:0] val;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] bus0;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m32 [16];
    logic [7:0]  m8 [4];
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic sb_pop(output exp_t e);
        check("scoreboard_nonempty", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '{rc: '0, val: '0, hi: '0, lo: '0, bus0: '0, lat: 0};
    endtask

    // Register-level reference model; updates model state and returns the expected result.
    function automatic exp_t model32(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                     input logic [3:0] rc, input logic [31:0] mdat);
        exp_t               e;
        logic signed [31:0] sa, sbv;
        longint             p;
        e.rc   = rc;
        e.bus0 = (op <= OpNot) ? m32[a] : 32'h0;
        e.val  = m32[rc];
        e.lat  = 4;
        sa     = m32[a];
        sbv    = m32[b];
        case (op)
            OpAdd: e.val = m32[a] + m32[b];
            OpSub: e.val = m32[a] - m32[b];
            OpAnd: e.val = m32[a] & m32[b];
            OpOr:  e.val = m32[a] | m32[b];
            OpNot: e.val = ~m32[a];
            OpMul: begin
                p     = longint'(sa) * longint'(sbv);
                e.val = p[31:0];
                hi_m  = p[63:32];
                lo_m  = p[31:0];
                e.lat = 5;
            end
            OpLoad: begin
                e.val = mdat;
                e.lat = 3;
            end
            default: e.lat = 2;
        endcase
        m32[rc] = e.val;
        e.hi    = hi_m;
        e.lo    = lo_m;
        return e;
    endfunction

    task automatic preload32(input logic [3:0] a, input logic [31:0] d);
        bi32.ld_en   = 1'b1;
        bi32.ld_addr = a;
        bi32.ld_data = d;
        m32[a]       = d;
        @(negedge clock);
        bi32.ld_en   = 1'b0;
    endtask

    task automatic preload8(input logic [1:0] a, input logic [7:0] d);
        bi8.ld_en   = 1'b1;
        bi8.ld_addr = a;
        bi8.ld_data = d;
        m8[a]       = d;
        @(negedge clock);
        bi8.ld_en   = 1'b0;
    endtask

    // Entered and left on a falling edge with the datapath idle.
    task automatic run32(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] rc, input logic [31:0] mdat);
        exp_t e;
        int   cyc = 1;
        int   busy_n = 0;
        bit   seen = 0;
        sb.push_back(model32(op, a, b, rc, mdat));
        bi32.start   = 1'b1;
        bi32.op      = op;
        bi32.ra      = a;
        bi32.rb      = b;
        bi32.rc      = rc;
        bi32.mdatain = mdat;
        @(negedge clock);
        bi32.start = 1'b0;
        bi32.ld_en = 1'b0;
        e = sb[0];
        while (cyc <= 12) begin
            if (cyc == 1) check("bus_t0", bi32.bus_out, e.bus0);
            if (cyc == 2 && op == OpLoad) check("bus_t1_load", bi32.bus_out, mdat);
            if (bi32.busy) busy_n++;
            if (bi32.done) begin
                seen = 1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        check("done_seen", 64'(seen), 64'd1);
        sb_pop(e);
        check("latency", 64'(cyc), 64'(e.lat));
        check("busy_cycles", 64'(busy_n), 64'(e.lat));
        bi32.dbg_addr = e.rc;
        #1;
        check("dest_reg", bi32.dbg_data, e.val);
        check("hi_out", bi32.hi_out, e.hi);
        check("lo_out", bi32.lo_out, e.lo);
        @(negedge clock);
        check("idle_after_done", 64'(bi32.busy), 64'd0);
    endtask

    task automatic run8(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] rc, input logic [7:0] hi_x, input logic [7:0] lo_x);
        exp_t e;
        int   cyc = 1;
        bit   seen = 0;
        e.rc  = {2'b00, rc};
        e.val = {24'h0, lo_x};
        e.lo  = {24'h0, lo_x};
        e.hi  = {24'h0, hi_x};
        e.bus0 = {24'h0, m8[a]};
        e.lat = (op == OpMul) ? 5 : 4;
        if (op != OpMul) e.lo = '0;
        m8[rc] = lo_x;
        sb.push_back(e);
        bi8.start = 1'b1;
        bi8.op    = op;
        bi8.ra    = a;
        bi8.rb    = b;
        bi8.rc    = rc;
        @(negedge clock);
        bi8.start = 1'b0;
        while (cyc <= 12) begin
            if (bi8.done) begin
                seen = 1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        check("w8_done_seen", 64'(seen), 64'd1);
        sb_pop(e);
        check("w8_latency", 64'(cyc), 64'(e.lat));
        bi8.dbg_addr = e.rc[1:0];
        #1;
        check("w8_dest_reg", 64'(bi8.dbg_data), 64'(e.val));
        check("w8_hi_out", 64'(bi8.hi_out), 64'(e.hi));
        check("w8_lo_out", 64'(bi8.lo_out), 64'(e.lo));
        @(negedge clock);
    endtask

    initial begin
        exp_t e;
        int   n;
        int   cnt;
        int   dcyc [2];

        bi32.start = 0; bi32.op = '0; bi32.ra = '0; bi32.rb = '0; bi32.rc = '0;
        bi32.mdatain = '0; bi32.ld_en = 0; bi32.ld_addr = '0; bi32.ld_data = '0;
        bi32.dbg_addr = '0;
        bi8.start = 0; bi8.op = '0; bi8.ra = '0; bi8.rb = '0; bi8.rc = '0;
        bi8.mdatain = '0; bi8.ld_en = 0; bi8.ld_addr = '0; bi8.ld_data = '0;
        bi8.dbg_addr = '0;
        for (int i = 0; i < 16; i++) m32[i] = '0;
        for (int i = 0; i < 4; i++) m8[i] = '0;

        // Reset values
        #1;
        check("rst_busy", 64'(bi32.busy), 64'd0);
        check("rst_done", 64'(bi32.done), 64'd0);
        check("rst_bus", bi32.bus_out, 64'd0);
        check("rst_hi", bi32.hi_out, 64'd0);
        check("rst_lo", bi32.lo_out, 64'd0);
        check("rst_r0", bi32.dbg_data, 64'd0);
        @(negedge clock);
        clear = 1'b1;

        // Reset during T2 of a MUL aborts it
        preload32(4'd1, 32'd5);
        preload32(4'd2, 32'd7);
        bi32.start = 1; bi32.op = OpMul; bi32.ra = 1; bi32.rb = 2; bi32.rc = 3;
        @(negedge clock);
        bi32.start = 0;
        @(negedge clock);
        @(negedge clock);
        check("abort_busy_before", 64'(bi32.busy), 64'd1);
        clear = 1'b0;
        #1;
        check("abort_busy", 64'(bi32.busy), 64'd0);
        check("abort_done", 64'(bi32.done), 64'd0);
        check("abort_hi", bi32.hi_out, 64'd0);
        check("abort_lo", bi32.lo_out, 64'd0);
        for (int i = 0; i < 16; i++) begin
            bi32.dbg_addr = 4'(i);
            #1;
            check($sformatf("abort_r%0d", i), bi32.dbg_data, 64'd0);
            m32[i] = '0;
        end
        @(negedge clock);
        clear = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (bi32.done) cnt++;
        end
        check("abort_no_done", 64'(cnt), 64'd0);

        // ADD, overflow, MUL, LOAD, aliasing SUB
        preload32(4'd1, 32'h0000_0005);
        preload32(4'd2, 32'h0000_0007);
        run32(OpAdd, 4'd1, 4'd2, 4'd3, 32'h0);
        preload32(4'd1, 32'hFFFF_FFFF);
        preload32(4'd2, 32'h0000_0001);
        run32(OpAdd, 4'd1, 4'd2, 4'd3, 32'h0);
        preload32(4'd4, 32'hFFFF_FFFE);
        preload32(4'd5, 32'h0000_0003);
        run32(OpMul, 4'd4, 4'd5, 4'd6, 32'h0);
        preload32(4'd4, 32'h8000_0000);
        preload32(4'd5, 32'h8000_0000);
        run32(OpMul, 4'd4, 4'd5, 4'd6, 32'h0);
        run32(OpLoad, 4'd0, 4'd0, 4'd7, 32'hDEAD_BEEF);
        run32(OpSub, 4'd7, 4'd7, 4'd7, 32'h0);

        // Bitwise ops and NOP (HI/LO must hold the last MUL result)
        preload32(4'd1, 32'hF0F0_1234);
        preload32(4'd2, 32'h0FF0_FFFF);
        preload32(4'd8, 32'h0000_0055);
        run32(OpAnd, 4'd1, 4'd2, 4'd9, 32'h0);
        run32(OpOr,  4'd1, 4'd2, 4'd9, 32'h0);
        run32(OpNot, 4'd1, 4'd2, 4'd10, 32'h0);
        run32(OpNop, 4'd1, 4'd2, 4'd8, 32'h0);

        // start and ld_en together: preload dropped
        preload32(4'd9, 32'h0000_0011);
        bi32.ld_en = 1; bi32.ld_addr = 4'd9; bi32.ld_data = 32'h0000_0099;
        run32(OpAdd, 4'd1, 4'd2, 4'd10, 32'h0);
        bi32.dbg_addr = 4'd9;
        #1;
        check("preload_dropped", bi32.dbg_data, 64'h11);

        // start held high: one issue per 5 cycles
        preload32(4'd1, 32'd3);
        preload32(4'd2, 32'd4);
        sb.push_back(model32(OpAdd, 4'd1, 4'd2, 4'd11, 32'h0));
        sb.push_back(model32(OpAdd, 4'd1, 4'd2, 4'd11, 32'h0));
        bi32.start = 1; bi32.op = OpAdd; bi32.ra = 1; bi32.rb = 2; bi32.rc = 11;
        n = 0;
        dcyc[0] = 0;
        dcyc[1] = 0;
        for (int cyc = 1; cyc <= 20 && n < 2; cyc++) begin
            @(negedge clock);
            if (bi32.done) begin
                dcyc[n] = cyc;
                n++;
                sb_pop(e);
                bi32.dbg_addr = e.rc;
                #1;
                check("held_dest_reg", bi32.dbg_data, e.val);
                if (n == 2) bi32.start = 0;
            end
        end
        bi32.start = 0;
        check("held_done_count", 64'(n), 64'd2);
        check("held_first_done", 64'(dcyc[0]), 64'd4);
        check("held_second_done", 64'(dcyc[1]), 64'd9);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (bi32.busy) cnt++;
        end
        check("held_no_reissue", 64'(cnt), 64'd0);

        // start pulse while busy is ignored
        preload32(4'd13, 32'h0000_0077);
        sb.push_back(model32(OpAdd, 4'd1, 4'd2, 4'd12, 32'h0));
        bi32.start = 1; bi32.op = OpAdd; bi32.ra = 1; bi32.rb = 2; bi32.rc = 12;
        cnt = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clock);
            bi32.start = (cyc == 2);
            if (cyc == 2) begin
                bi32.op = OpMul; bi32.rc = 13;
            end
            if (bi32.done) begin
                cnt++;
                sb_pop(e);
                bi32.dbg_addr = e.rc;
                #1;
                check("busy_pulse_dest", bi32.dbg_data, e.val);
            end
        end
        bi32.start = 0;
        check("busy_pulse_one_done", 64'(cnt), 64'd1);
        bi32.dbg_addr = 4'd13;
        #1;
        check("busy_pulse_r13", bi32.dbg_data, 64'h77);
        @(negedge clock);

        // 8-bit, 4-register instance
        preload8(2'd0, 8'h80);
        preload8(2'd1, 8'h80);
        run8(OpAdd, 2'd0, 2'd1, 2'd2, 8'h00, 8'h00);
        preload8(2'd0, 8'h7F);
        preload8(2'd1, 8'h7F);
        run8(OpMul, 2'd0, 2'd1, 2'd3, 8'h3F, 8'h01);
        for (int i = 0; i < 4; i++) begin
            bi8.dbg_addr = 2'(i);
            #1;
            check($sformatf("w8_dbg_r%0d", i), 64'(bi8.dbg_data), 64'(m8[i]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
